seq_sign_multiplier: RTL and testbench
======================================

# seq_sign_multiplier

Sequential signed shift-add multiplier. Takes two two's-complement operands, multiplies their magnitudes over `WORD_LENGTH` cycles, then applies the product sign. The product sign comes from the existing combinational sign stage, which this block enables and consumes. Sits between the operand registers and the result/display path of the multiply-divide-root unit.

## Interface
- `WORD_LENGTH`, default 16: operand width in bits; result is `2*WORD_LENGTH`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1: request a multiply; sampled only in IDLE.
- `multiplicand`  in  WORD_LENGTH: two's-complement operand A.
- `multiplier`  in  WORD_LENGTH: two's-complement operand B.
- `sign`  in  1: product sign from the sign stage; that stage's inputs are the operand MSBs.
- `sign_enable`  out  1: drives the sign stage's enable; high only in LOAD.
- `busy`  out  1: high in LOAD, SHIFT and FIX.
- `ready`  out  1: one-cycle pulse in DONE; `result` is valid.
- `result`  out  2*WORD_LENGTH: signed product; holds until the next LOAD.

## Operation
- States: IDLE, LOAD, SHIFT, FIX, DONE.
- IDLE: if `start`=1, go to LOAD; otherwise stay.
- LOAD:
  - Register `|multiplicand|` (zero-extended to 2W bits) and `|multiplier|` (W bits).
  - Latch `sign`; clear the accumulator and `result`; load counter = WORD_LENGTH-1; go to SHIFT.
- Magnitude rule: `-2^(W-1)` maps to `2^(W-1)`, unsigned W bits, with no overflow. The maximum magnitude product is `2^(2W-2)` and fits in 2W bits.
- SHIFT, once per cycle:
  - If multiplier LSB = 1, accumulator += multiplicand.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Decrement the counter; after the iteration at counter 0, go to FIX.
- FIX: `result` = latched sign ? (~acc + 1) : acc; go to DONE.
- Zero product: a zero product always yields `result`=0. This holds even when `sign` is 1 (e.g. 0 × -5), because the negation of 0 is 0.
- DONE: `ready`=1; go to IDLE unconditionally. `start` in DONE is ignored.
- `start` in any state other than IDLE is ignored; operand changes after LOAD have no effect.
- Reset (`reset`=0 at any edge, including mid-SHIFT):
  - State goes to IDLE.
  - Accumulator, counter, `result` and latched sign are cleared.
  - `ready`, `busy` and `sign_enable` are 0.

## Timing
- Cycle 0: `start`=1 sampled in IDLE.
- Cycle 1: LOAD; `sign_enable`=1.
- Cycles 2 to W+1: SHIFT.
- Cycle W+2: FIX.
- Cycle W+3: DONE; `ready`=1 and `result` is valid.
- Latency from start to ready is W+3 cycles (19 for W=16).
- Earliest next accepted `start` is cycle W+4 (IDLE), so the initiation interval is W+4.
- `result` is registered. It is stable from FIX+1 until the next LOAD clears it.
- Reset values: `busy`=0, `ready`=0, `sign_enable`=0, `result`=0.

## Configuration
- `MULT_ZERO_EARLY_EN` defined:
  - In LOAD, if either operand is 0, skip SHIFT and FIX; `result` stays 0 and the next state is DONE.
  - Latency is 2 cycles for those operands.
- `MULT_ZERO_EARLY_EN` undefined: every operation takes the full W+3 cycles. Results are identical in both cases.

## Structure
- Package `mult_pkg` contains:
  - The state enum type.
  - The `WORD_LENGTH` default constant.
  - The counter width constant, `$clog2(WORD_LENGTH)`.
- One sub-module, `twos_complement`: a combinational conditional negate. It is instanced twice for the operand magnitudes (MSB as the control) and once for the FIX stage.
- The sign stage stays outside this block and is wired at the parent level.

## Test plan
- W=16, A=3, B=-4, start pulse → `ready` at cycle 19, `result`=32'hFFFF_FFF4, `sign_enable` high only in cycle 1.
- A=-32768, B=-32768 → `result`=32'h4000_0000, with no magnitude overflow.
- A=0, B=-5 with sign stage output 1 → `result`=0. Latency is 19 cycles with the macro undefined and 2 cycles with `MULT_ZERO_EARLY_EN` defined.
- A=7, B=9 start; re-assert `start` with A=1, B=1 during SHIFT → second start ignored, `result`=63, one `ready` pulse.
- A=100, B=-3; drive `reset`=0 at cycle 8 → next cycle in IDLE with `busy`=`ready`=0 and `result`=0. A following start with A=2, B=2 gives `result`=4.
- Back-to-back runs: start at the first IDLE cycle after DONE with A=-1, B=-1 → `result`=1, initiation interval 20 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed multiplier.
// MULT_ZERO_EARLY_EN is consumed by seq_sign_multiplier, not here.
package mult_pkg;

  localparam int WORD_LENGTH_DEF = 16;
  localparam int CNT_W           = $clog2(WORD_LENGTH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/twos_complement.sv
// Combinational conditional negate: dout = neg ? -din : din (two's complement).
module twos_complement #(
  parameter int W = 16
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_sign_multiplier.sv
// Sequential signed shift-add multiplier: magnitudes are multiplied over WORD_LENGTH
// cycles, then the externally computed sign is applied. Option: MULT_ZERO_EARLY_EN.
module seq_sign_multiplier
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic [WORD_LENGTH-1:0]   multiplier,
  input  logic                     sign,
  output logic                     sign_enable,
  output logic                     busy,
  output logic                     ready,
  output logic [2*WORD_LENGTH-1:0] result
);

  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH);

  state_t          state;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            sign_q;

  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [2*W-1:0]  fix_val;

  // The most negative operand maps to 2^(W-1), which still fits as unsigned W bits.
  twos_complement #(.W(W)) u_mag_a (
    .neg  (multiplicand[W-1]),
    .din  (multiplicand),
    .dout (mag_a)
  );

  twos_complement #(.W(W)) u_mag_b (
    .neg  (multiplier[W-1]),
    .din  (multiplier),
    .dout (mag_b)
  );

  twos_complement #(.W(2*W)) u_fix (
    .neg  (sign_q),
    .din  (acc),
    .dout (fix_val)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      result      <= '0;
      sign_enable <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            sign_enable <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          mcand       <= {{W{1'b0}}, mag_a};
          mplier      <= mag_b;
          sign_q      <= sign;
          acc         <= '0;
          result      <= '0;
          cnt         <= CW'(W-1);
          sign_enable <= 1'b0;
`ifdef MULT_ZERO_EARLY_EN
          // A zero operand already has its final result (0) in place.
          if (multiplicand == '0 || multiplier == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            state <= SHIFT;
          end
`else
          state       <= SHIFT;
`endif
        end
        SHIFT: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
          busy   <= 1'b0;
          ready  <= 1'b1;
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          sign_enable <= 1'b0;
          busy        <= 1'b0;
          ready       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sign_multiplier.sv
// Directed bench for seq_sign_multiplier (W=16) with a behavioural XOR sign stage.
module tb_seq_sign_multiplier;

  localparam int W = 16;
`ifdef MULT_ZERO_EARLY_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 3;
`endif
  localparam int FLAT = W + 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           sign;
  logic           sign_enable;
  logic           busy;
  logic           ready;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  seq_sign_multiplier #(.WORD_LENGTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .sign         (sign),
    .sign_enable  (sign_enable),
    .busy         (busy),
    .ready        (ready),
    .result       (result)
  );

  // Parent-level sign stage: XOR of operand MSBs, gated by its enable.
  assign sign = sign_enable & (multiplicand[W-1] ^ multiplier[W-1]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one multiply from IDLE and follow it to ready. Optionally re-pulse start
  // with A=B=1 in cycle poke. Returns with the bench in the IDLE cycle after DONE.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                     input int poke, output int lat, output int t0,
                     output int errs, output logic [2*W-1:0] res);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b0;
    lat   = 0;
    errs  = 0;
    res   = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n == poke) begin
        multiplicand = 1;
        multiplier   = 1;
        start        = 1'b1;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (sign_enable !== (n == 1)) errs++;
      if (busy !== (n < exp_lat)) errs++;
      if (ready === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  int             lat, t0, t1, errs, rcnt;
  logic [2*W-1:0] res;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_sen",   64'(sign_enable), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(posedge clk); #1;

    run(16'd3, 16'hFFFC, FLAT, 0, lat, t0, errs, res);
    chk("3x-4_res", 64'(res), 64'hFFFF_FFF4);
    chk("3x-4_lat", 64'(lat), 64'(FLAT));
    chk("3x-4_ctl", 64'(errs), 64'd0);
    @(negedge clk);
    chk("3x-4_hold", 64'(result), 64'hFFFF_FFF4);
    @(posedge clk); #1;

    run(16'h8000, 16'h8000, FLAT, 0, lat, t0, errs, res);
    chk("minxmin_res", 64'(res), 64'h4000_0000);
    chk("minxmin_ctl", 64'(errs), 64'd0);

    run(16'h8000, 16'h7FFF, FLAT, 0, lat, t0, errs, res);
    chk("minxmax_res", 64'(res), 64'hC000_8000);

    run(16'h7FFF, 16'h7FFF, FLAT, 0, lat, t0, errs, res);
    chk("maxxmax_res", 64'(res), 64'h3FFF_0001);

    run(16'd123, -16'sd45, FLAT, 0, lat, t0, errs, res);
    chk("123x-45_res", 64'(res), 64'hFFFF_EA61);

    run(16'd0, 16'hFFFB, ZLAT, 0, lat, t0, errs, res);
    chk("0x-5_res", 64'(res), 64'd0);
    chk("0x-5_lat", 64'(lat), 64'(ZLAT));
    chk("0x-5_ctl", 64'(errs), 64'd0);

    run(16'd7, 16'd9, FLAT, 5, lat, t0, errs, res);
    chk("7x9_res", 64'(res), 64'd63);
    chk("7x9_lat", 64'(lat), 64'(FLAT));
    chk("7x9_ctl", 64'(errs), 64'd0);
    rcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ready === 1'b1) rcnt++;
    end
    chk("7x9_extra_ready", 64'(rcnt), 64'd0);
    @(posedge clk); #1;

    // Reset in cycle 8 of a run.
    multiplicand = 16'd100;
    multiplier   = 16'hFFFD;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   64'(busy), 64'd0);
    chk("midrst_ready",  64'(ready), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    @(posedge clk); #1;

    run(16'd2, 16'd2, FLAT, 0, lat, t0, errs, res);
    chk("2x2_res", 64'(res), 64'd4);
    chk("2x2_lat", 64'(lat), 64'(FLAT));

    run(16'hFFFF, 16'hFFFF, FLAT, 0, lat, t0, errs, res);
    chk("m1xm1_res", 64'(res), 64'd1);
    run(16'hFFFF, 16'hFFFF, FLAT, 0, lat, t1, errs, res);
    chk("m1xm1_b2b_res", 64'(res), 64'd1);
    chk("m1xm1_ii", 64'(t1 - t0), 64'(W + 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
